psram_ctrl: RTL and testbench
=============================

PSRAM_CTRL -- requirements
Module: psram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL be the external data bus width, a multiple of 8; BE_W = DATA_W/8.
REQ-002 Parameter ADDR_W, default 26, SHALL be the word address width.
REQ-003 Parameter LEN_W, default 4, SHALL be the burst length field width; a burst is req_len+1 beats.
REQ-004 Parameter T_ACC, default 8, SHALL be the number of clk cycles each strobe (OE or WE) is held low.
REQ-005 Parameter T_REC, default 2, SHALL be the number of idle cycles between beats, with CS high.
REQ-006 Parameter T_INIT, default 15000, SHALL be the number of power-up wait cycles after reset.
REQ-007 clk  in  1  system clock, 100 MHz; all logic on the rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 req_valid  in  1  request present; req_ready  out  1  controller accepts this cycle.
REQ-010 req_we  in  1  1=write, 0=read; req_addr  in  ADDR_W  start word address; req_len  in  LEN_W  beats-1; req_be  in  BE_W  active-high byte enables.
REQ-011 wdata  in  DATA_W  write data for the current beat; wd_take  out  1  one-cycle pulse, wdata captured.
REQ-012 rdata  out  DATA_W  read beat data; rd_valid  out  1  one-cycle pulse per read beat.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 Memory pins: RamAdv, RamClk, RamCS, MemOE, MemWR out 1 each; RamLB/RamUB out BE_W total (active-low byte lanes); MemAdr out ADDR_W; MemDB inout DATA_W.

Function
REQ-015 States SHALL be INIT, IDLE, ACCESS, RECOVER.
REQ-016 INIT SHALL count T_INIT cycles with all strobes high, then go to IDLE; req_ready SHALL be 0 in INIT.
REQ-017 req_ready SHALL equal 1 only in IDLE; a transfer is accepted on a cycle where req_valid and req_ready are both 1.
REQ-018 On acceptance the controller SHALL latch we, addr, len, be and enter ACCESS on the next cycle.
REQ-019 A write beat SHALL capture wdata on the first ACCESS cycle, pulse wd_take that cycle, and drive MemDB for the whole beat.
REQ-020 ACCESS SHALL hold RamCS=0 plus MemOE=0 (read) or MemWR=0 (write) for exactly T_ACC cycles; RamLB/RamUB SHALL equal ~be.
REQ-021 A read beat SHALL sample MemDB on the last ACCESS cycle; the sampled word SHALL appear on rdata with rd_valid=1 on the following cycle.
REQ-022 After each beat RECOVER SHALL hold all strobes high for T_REC cycles and tri-state MemDB; write data SHALL stay driven during the first RECOVER cycle (hold time).
REQ-023 After RECOVER the controller SHALL start the next beat at addr+1, wrapping modulo 2^ADDR_W, or return to IDLE after the last beat.
REQ-024 rdata SHALL hold its last value between pulses.
REQ-025 RamAdv and RamClk SHALL be constant 0 (asynchronous mode).
REQ-026 MemDB SHALL be high-Z in every cycle except write ACCESS and the first RECOVER cycle after a write.
REQ-027 req_len=0 SHALL give one beat; req_be=0 SHALL still run full timing with all lanes disabled.

Reset
REQ-028 Asserting rst SHALL immediately force RamCS, MemOE, MemWR, RamLB, RamUB high and MemDB high-Z, asynchronously, including mid-beat.
REQ-029 Reset values SHALL be: state INIT, req_ready 0, busy 1, rd_valid 0, wd_take 0, rdata 0, MemAdr 0.
REQ-030 On reset release the full T_INIT wait SHALL rerun; an aborted burst SHALL NOT resume.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the default timing constants for the 100 MHz clock.
REQ-032 One sub-module, psram_timer, SHALL be a loadable down-counter with zero flag, reused for the INIT, ACCESS and RECOVER intervals.

Verification
REQ-033 Reset, T_INIT=20: req_ready SHALL stay 0 for 20 cycles, then rise; strobes SHALL stay high throughout.
REQ-034 Single write addr=0x10, data 0xBEEF, be=2'b11: MemWR SHALL be low for exactly 8 cycles, MemDB=0xBEEF, MemAdr=0x10, one wd_take pulse.
REQ-035 Read back addr=0x10 using a memory model: rd_valid SHALL pulse once with rdata=0xBEEF, 9 cycles after ACCESS entry.
REQ-036 Read burst at addr=2^26-2, len=3: 4 rd_valid pulses at addresses 0x3FFFFFE, 0x3FFFFFF, 0, 1, with each beat spaced T_ACC+T_REC cycles apart.
REQ-037 Write be=2'b01: RamLB SHALL be 0 and RamUB 1 for the whole beat; the model's upper byte SHALL be unchanged.
REQ-038 Assert rst during the 3rd write beat: strobes SHALL go high within the same cycle; after release, INIT SHALL rerun and no further beats SHALL occur.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared definitions for the asynchronous PSRAM controller: FSM states,
// default timing for a 100 MHz clock and the interval-counter width helper.
package psram_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } psram_state_t;

    // 100 MHz: 80 ns strobe, 20 ns CS-high recovery, 150 us power-up wait
    localparam int DEF_T_ACC  = 8;
    localparam int DEF_T_REC  = 2;
    localparam int DEF_T_INIT = 15000;

    // Width able to hold (largest interval - 1); never narrower than one bit
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/psram_timer.sv
// Loadable down-counter with zero flag; times the INIT, ACCESS and RECOVER
// intervals. A load of N gives N+1 cycles before the flag is seen.
module psram_timer #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= RST_VAL;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/psram_ctrl.sv
// Asynchronous-mode PSRAM controller: word bursts with fixed strobe width and
// CS-high recovery between beats, after a power-up wait.
module psram_ctrl
    import psram_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  ADDR_W = 26,
    parameter int  LEN_W  = 4,
    parameter int  T_ACC  = DEF_T_ACC,
    parameter int  T_REC  = DEF_T_REC,
    parameter int  T_INIT = DEF_T_INIT,
    localparam int BE_W   = DATA_W / 8,
    localparam int LB_W   = (BE_W + 1) / 2,
    localparam int UB_W   = (BE_W > 1) ? (BE_W - LB_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] wdata,
    output logic              wd_take,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              RamAdv,
    output logic              RamClk,
    output logic              RamCS,
    output logic              MemOE,
    output logic              MemWR,
    output logic [LB_W-1:0]   RamLB,
    output logic [UB_W-1:0]   RamUB,
    output logic [ADDR_W-1:0] MemAdr,
    inout  wire  [DATA_W-1:0] MemDB
);

    localparam int               CNT_W     = timer_width(T_ACC, T_REC, T_INIT);
    localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] REC_LOAD  = CNT_W'(T_REC - 1);
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(T_INIT - 1);

    psram_state_t      state_reg;
    logic              we_reg;
    logic [LEN_W-1:0]  left_reg;
    logic [BE_W-1:0]   be_reg;
    logic [ADDR_W-1:0] adr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              drive_reg;
    logic              cs_n_reg;
    logic              oe_n_reg;
    logic              wr_n_reg;
    logic [BE_W-1:0]   lanes_n_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              rd_valid_reg;
    logic              wd_take_reg;

    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_zero;

    psram_timer #(
        .W       (CNT_W),
        .RST_VAL (INIT_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_comb begin
        timer_load = 1'b0;
        timer_val  = ACC_LOAD;
        unique case (state_reg)
            ST_IDLE:    timer_load = req_valid;
            ST_ACCESS: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = REC_LOAD;
                end
            end
            ST_RECOVER: timer_load = timer_zero && (left_reg != '0);
            default:    timer_load = 1'b0;
        endcase
    end

    // Every pin-side output is a flop with async preset so reset parks the
    // bus at once, even in the middle of a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            we_reg       <= 1'b0;
            left_reg     <= '0;
            be_reg       <= '0;
            adr_reg      <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            drive_reg    <= 1'b0;
            cs_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            wr_n_reg     <= 1'b1;
            lanes_n_reg  <= '1;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            rd_valid_reg <= 1'b0;
            wd_take_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            wd_take_reg  <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (timer_zero) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        state_reg   <= ST_ACCESS;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        we_reg      <= req_we;
                        left_reg    <= req_len;
                        be_reg      <= req_be;
                        adr_reg     <= req_addr;
                        cs_n_reg    <= 1'b0;
                        oe_n_reg    <= req_we;
                        wr_n_reg    <= !req_we;
                        lanes_n_reg <= ~req_be;
                        wdata_reg   <= wdata;
                        drive_reg   <= req_we;
                        wd_take_reg <= req_we;
                    end
                end
                ST_ACCESS: begin
                    if (timer_zero) begin
                        state_reg   <= ST_RECOVER;
                        cs_n_reg    <= 1'b1;
                        oe_n_reg    <= 1'b1;
                        wr_n_reg    <= 1'b1;
                        lanes_n_reg <= '1;
                        if (!we_reg) begin
                            rdata_reg    <= MemDB;
                            rd_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    // write data stays on the bus for one recovery cycle only
                    drive_reg <= 1'b0;
                    if (timer_zero) begin
                        if (left_reg == '0) begin
                            state_reg <= ST_IDLE;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg   <= ST_ACCESS;
                            left_reg    <= left_reg - LEN_W'(1);
                            adr_reg     <= adr_reg + ADDR_W'(1);
                            cs_n_reg    <= 1'b0;
                            oe_n_reg    <= we_reg;
                            wr_n_reg    <= !we_reg;
                            lanes_n_reg <= ~be_reg;
                            wdata_reg   <= wdata;
                            drive_reg   <= we_reg;
                            wd_take_reg <= we_reg;
                        end
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign rd_valid  = rd_valid_reg;
    assign wd_take   = wd_take_reg;
    assign rdata     = rdata_reg;
    assign RamAdv    = 1'b0;
    assign RamClk    = 1'b0;
    assign RamCS     = cs_n_reg;
    assign MemOE     = oe_n_reg;
    assign MemWR     = wr_n_reg;
    assign MemAdr    = adr_reg;
    assign MemDB     = drive_reg ? wdata_reg : {DATA_W{1'bz}};
    assign RamLB     = lanes_n_reg[LB_W-1:0];

    generate
        if (BE_W > 1) begin : g_ub
            assign RamUB = lanes_n_reg[BE_W-1:LB_W];
        end else begin : g_ub_tie
            assign RamUB = '1;
        end
    endgenerate

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: pin-level PSRAM model, directed transaction table,
// randomized transfers against a word-memory reference, and reset corners.
module tb_psram_ctrl;

    localparam int T_ACC  = 8;
    localparam int T_REC  = 2;
    localparam int T_INIT = 20;
    localparam int BEAT   = T_ACC + T_REC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [25:0] req_addr;
    logic [3:0]  req_len;
    logic [1:0]  req_be;
    logic [15:0] wdata, rdata;
    logic        wd_take, rd_valid, busy;
    logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
    logic [25:0] MemAdr;
    wire  [15:0] MemDB;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    psram_ctrl #(
        .DATA_W (16), .ADDR_W (26), .LEN_W (4),
        .T_ACC  (T_ACC), .T_REC (T_REC), .T_INIT (T_INIT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_len (req_len), .req_be (req_be),
        .wdata (wdata), .wd_take (wd_take), .rdata (rdata), .rd_valid (rd_valid),
        .busy (busy), .RamAdv (RamAdv), .RamClk (RamClk), .RamCS (RamCS),
        .MemOE (MemOE), .MemWR (MemWR), .RamLB (RamLB), .RamUB (RamUB),
        .MemAdr (MemAdr), .MemDB (MemDB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- pin-level PSRAM model and reference memory ----------------
    logic [15:0] pmem    [logic [25:0]];
    logic [15:0] ref_mem [logic [25:0]];
    logic [15:0] tb_dq = 16'h0;
    logic        tb_drive = 1'b0;
    assign MemDB = tb_drive ? tb_dq : 16'hzzzz;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] en);
        logic [15:0] r;
        r = old;
        for (int j = 0; j < 2; j++) if (en[j]) r[j*8 +: 8] = nw[j*8 +: 8];
        return r;
    endfunction

    function automatic logic [15:0] pm_rd(input logic [25:0] a);
        return pmem.exists(a) ? pmem[a] : 16'h0;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [25:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    bit          pend = 0;
    logic [25:0] p_adr;
    logic [15:0] p_dat;
    logic [1:0]  p_en;

    // Commit a write when WE rises; a write cut short by reset is dropped.
    always @(negedge clk) begin
        if (!RamCS && !MemOE) begin
            tb_drive = 1'b1;
            tb_dq    = pm_rd(MemAdr);
        end else begin
            tb_drive = 1'b0;
        end
        if (!RamCS && !MemWR) begin
            pend  = 1;
            p_adr = MemAdr;
            p_dat = MemDB;
            p_en  = ~{RamUB, RamLB};
        end else if (pend) begin
            pend = 0;
            if (rst_n) pmem[p_adr] = merge(pm_rd(p_adr), p_dat, p_en);
        end
    end

    // ---------------- one transfer, checked cycle by cycle ----------------
    task automatic do_xfer(input bit we, input logic [25:0] addr, input logic [3:0] len,
                           input logic [1:0] be, input logic [15:0] d0,
                           input bit has_exp, input logic [15:0] exp_first);
        int          acc, n, beats, rdn, wdn, run_len, run_start, wait_n;
        bit          in_run, stable, stray, ready_bad;
        logic [25:0] run_adr, a;
        logic [15:0] run_dq, last_rd, dexp;
        logic [1:0]  run_ln, ln_exp;
        logic [15:0] exp_rd [$];
        n = int'(len) + 1;
        ln_exp = ~be;
        for (int i = 0; i < n; i++) begin
            a = addr + 26'(i);
            exp_rd.push_back(ref_rd(a));
        end
        wait_n = 0;
        while (!req_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_len = len; req_be = be; wdata = d0;
        acc = cyc;
        @(negedge clk);
        req_valid = 0; req_we = 1'($urandom); req_addr = 26'($urandom);
        req_len = 4'($urandom); req_be = 2'($urandom);
        beats = 0; rdn = 0; wdn = 0; in_run = 0; stable = 1; stray = 0; ready_bad = 0;
        run_len = 0; run_start = 0; run_adr = '0; run_dq = '0; run_ln = '0; last_rd = '0;
        for (int c = 0; c < n * BEAT + 20; c++) begin
            if (wd_take) begin
                wdn++;
                wdata = d0 + 16'(wdn);
            end
            if (rd_valid) begin
                chk("rd_time", cyc - acc, 1 + rdn * BEAT + T_ACC);
                if (rdn < n) chk("rd_data", rdata, exp_rd[rdn]);
                if (rdn == 0 && has_exp) chk("rd_first", rdata, exp_first);
                last_rd = rdata;
                rdn++;
            end
            if (req_ready && busy) ready_bad = 1;
            if (!RamCS && (we ? !MemOE : !MemWR)) stray = 1;
            if (!RamCS && (we ? !MemWR : !MemOE)) begin
                if (!in_run) begin
                    in_run = 1; run_len = 0; run_start = cyc; stable = 1;
                    run_adr = MemAdr; run_dq = MemDB; run_ln = {RamUB, RamLB};
                end
                run_len++;
                if (MemAdr != run_adr || {RamUB, RamLB} != run_ln || (we && MemDB != run_dq))
                    stable = 0;
            end else if (in_run) begin
                in_run = 0;
                a = addr + 26'(beats);
                dexp = d0 + 16'(beats);
                chk("beat_start", run_start - acc, 1 + beats * BEAT);
                chk("beat_len", run_len, T_ACC);
                chk("beat_adr", run_adr, a);
                chk("beat_lanes", run_ln, ln_exp);
                chk("beat_stable", stable, 1);
                if (we) begin
                    chk("wr_data", run_dq, dexp);
                    chk("wr_hold", MemDB, dexp);
                end
                beats++;
            end
            if (!busy) break;
            @(negedge clk);
        end
        chk("xfer_done", busy, 0);
        chk("beat_count", beats, n);
        chk("other_strobe", stray, 0);
        chk("ready_while_busy", ready_bad, 0);
        if (we) begin
            chk("wd_take_count", wdn, n);
            for (int i = 0; i < n; i++) begin
                a = addr + 26'(i);
                dexp = d0 + 16'(i);
                ref_mem[a] = merge(ref_rd(a), dexp, be);
            end
        end else begin
            chk("rd_valid_count", rdn, n);
            repeat (3) @(negedge clk);
            chk("rdata_hold", rdata, last_rd);
        end
        $display("xfer %s addr=0x%07h len=%0d be=%b d0=0x%04h beats=%0d", we ? "WR" : "RD",
                 addr, len, be, d0, beats);
    endtask

    // Checks the power-up wait after a reset release made at a falling edge.
    task automatic init_check(input string tag);
        bit early, strobe_lo;
        early = 0; strobe_lo = 0;
        for (int k = 1; k <= T_INIT; k++) begin
            @(negedge clk);
            if (k < T_INIT && req_ready) early = 1;
            if (!RamCS || !MemOE || !MemWR || !RamLB || !RamUB) strobe_lo = 1;
        end
        chk({tag, "_ready_low"}, early, 0);
        chk({tag, "_ready_rise"}, req_ready, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_strobes_high"}, strobe_lo, 0);
    endtask

    typedef struct {
        bit          we;
        logic [25:0] addr;
        logic [3:0]  len;
        logic [1:0]  be;
        logic [15:0] data;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          runs, wdn;
        bit          lo, prev_lo, any_low;
        bit          we;
        logic [25:0] addr, k;
        logic [3:0]  len;
        logic [1:0]  be;
        logic [15:0] d;

        vecs[0] = '{1'b1, 26'h10,      4'd0, 2'b11, 16'hBEEF, 16'h0};
        vecs[1] = '{1'b0, 26'h10,      4'd0, 2'b11, 16'h0,    16'hBEEF};
        vecs[2] = '{1'b1, 26'h10,      4'd0, 2'b01, 16'h1234, 16'h0};
        vecs[3] = '{1'b0, 26'h10,      4'd0, 2'b11, 16'h0,    16'hBE34};
        vecs[4] = '{1'b1, 26'h3FFFFFE, 4'd3, 2'b11, 16'hA000, 16'h0};
        vecs[5] = '{1'b0, 26'h3FFFFFE, 4'd3, 2'b11, 16'h0,    16'hA000};
        vecs[6] = '{1'b1, 26'h20,      4'd0, 2'b00, 16'hFFFF, 16'h0};
        vecs[7] = '{1'b0, 26'h20,      4'd0, 2'b11, 16'h0,    16'h0000};

        req_valid = 0; req_we = 0; req_addr = '0; req_len = '0; req_be = '0; wdata = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wd_take", wd_take, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_memadr", MemAdr, 0);
        chk("rst_strobes", {RamCS, MemOE, MemWR, RamLB, RamUB}, 5'h1F);
        chk("async_mode_pins", {RamAdv, RamClk}, 2'b00);
        rst_n = 1;
        init_check("init");

        for (int i = 0; i < 8; i++)
            do_xfer(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].be, vecs[i].data,
                    !vecs[i].we, vecs[i].exp_first);

        for (int t = 0; t < 14; t++) begin
            we  = 1'($urandom_range(0, 1));
            len = 4'($urandom_range(0, 5));
            be  = 2'($urandom_range(0, 3));
            d   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) addr = 26'h3FFFFFC + 26'($urandom_range(0, 3));
            else                           addr = 26'h100 + 26'($urandom_range(0, 31));
            do_xfer(we, addr, len, be, d, 1'b0, 16'h0);
        end

        // Reset in the middle of the third beat of a five-beat write
        while (!req_ready) @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 26'h40; req_len = 4'd4; req_be = 2'b11;
        wdata = 16'h5000;
        @(negedge clk);
        req_valid = 0;
        runs = 0; wdn = 0; prev_lo = 0;
        for (int c = 0; c < 100; c++) begin
            if (wd_take) begin
                wdn++;
                wdata = 16'h5000 + 16'(wdn);
            end
            lo = !MemWR;
            if (lo && !prev_lo) runs++;
            prev_lo = lo;
            if (runs == 3 && lo) break;
            @(negedge clk);
        end
        chk("abort_third_beat", runs, 3);
        repeat (3) @(negedge clk);
        chk("abort_midbeat_wr_low", MemWR, 0);
        #2 rst_n = 0;
        #1;
        chk("abort_strobes_now", {RamCS, MemOE, MemWR, RamLB, RamUB}, 5'h1F);
        chk("abort_ready", req_ready, 0);
        chk("abort_busy", busy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        init_check("reinit");
        any_low = 0;
        repeat (40) begin
            @(negedge clk);
            if (!RamCS || !MemWR || !MemOE) any_low = 1;
        end
        chk("abort_no_resume", any_low, 0);
        chk("abort_idle", busy, 0);
        ref_mem[26'h40] = 16'h5000;
        ref_mem[26'h41] = 16'h5001;

        if (ref_mem.first(k)) begin
            do begin
                chk("mem_final", pm_rd(k), ref_mem[k]);
            end while (ref_mem.next(k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
